cdp_rdma_dp_tx: RTL



---
 rtl/cdp_rdma_dp_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cdp_rdma_dp_tx.sv
// CDP RDMA->DP transmit stage: tags each returned element with lane/position flags and drives
// the valid/ready stream into the datapath. Optional stall counter: CDP_RDMA_TX_STALL_CNT_EN.
module cdp_rdma_dp_tx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned INFO_W = 23,
   parameter int unsigned CNT_W  = 13
) (
   input  logic                      nvdla_core_clk,
   input  logic                      nvdla_core_rstn,
   input  logic                      reg2dp_op_en,
   input  logic [CNT_W-1:0]          reg2dp_width,
   input  logic [CNT_W-1:0]          reg2dp_height,
   input  logic [CNT_W-1:0]          reg2dp_channel,
   input  logic [DATA_W-1:0]         rd_data,
   input  logic                      rd_valid,
   output logic                      rd_ready,
   output logic [DATA_W+INFO_W-1:0]  cdp_rdma2dp_pd,
   output logic                      cdp_rdma2dp_valid,
   input  logic                      cdp_rdma2dp_ready,
`ifdef CDP_RDMA_TX_STALL_CNT_EN
   output logic [31:0]               dp2reg_rdma_stall,
`endif
   output logic                      rdma2glb_done
);

   localparam int unsigned GrpW = CNT_W - 3;
   localparam logic [CNT_W-1:0] CntOne = 1;
   localparam logic [GrpW-1:0]  GrpOne = 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                     state_q, state_d;
   logic                       op_en_d1_q;
   logic [CNT_W-1:0]           width_q, height_q, channel_q;
   logic [2:0]                 lane_q, lane_d;
   logic [CNT_W-1:0]           w_q, w_d, h_q, h_d;
   logic [GrpW-1:0]            cgrp_q, cgrp_d;
   logic                       valid_q;
   logic [DATA_W+INFO_W-1:0]   pd_q;
   logic                       done_q;

   logic                       op_en_rise, rd_fire, out_fire;
   logic                       last_c, last_w, last_h, atom_end, line_end, surf_end, layer_last;
   logic [2:0]                 last_lane;
   logic [INFO_W-1:0]          info;

   assign op_en_rise = reg2dp_op_en & ~op_en_d1_q;
   assign out_fire   = valid_q & cdp_rdma2dp_ready;
   assign rd_ready   = (state_q == StRun) & (~valid_q | cdp_rdma2dp_ready);
   assign rd_fire    = rd_valid & rd_ready;

   // The final channel group may be partial; its last lane comes from channel[2:0].
   assign last_c     = (cgrp_q == channel_q[CNT_W-1:3]);
   assign last_lane  = last_c ? channel_q[2:0] : 3'd7;
   assign atom_end   = (lane_q == last_lane);
   assign last_w     = (w_q == width_q);
   assign last_h     = (h_q == height_q);
   assign line_end   = atom_end & last_w;
   assign surf_end   = line_end & last_h;
   assign layer_last = surf_end & last_c;

   always_comb begin
      info     = '0;
      info[2:0] = lane_q;
      info[8]  = atom_end;
      info[9]  = line_end;
      info[10] = surf_end;
      info[11] = layer_last;
      info[12] = last_w;
      info[13] = last_h;
      info[14] = last_c;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (op_en_rise) state_d = StRun;
         StRun:   if (rd_fire && layer_last) state_d = StDrain;
         StDrain: if (out_fire) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Traversal: lane fastest, then w, then h, then channel group.
   always_comb begin
      lane_d = lane_q;
      w_d    = w_q;
      h_d    = h_q;
      cgrp_d = cgrp_q;
      if (state_q == StIdle) begin
         lane_d = '0;
         w_d    = '0;
         h_d    = '0;
         cgrp_d = '0;
      end else if (rd_fire) begin
         if (!atom_end) begin
            lane_d = lane_q + 3'd1;
         end else begin
            lane_d = '0;
            if (!last_w) begin
               w_d = w_q + CntOne;
            end else begin
               w_d = '0;
               if (!last_h) begin
                  h_d = h_q + CntOne;
               end else begin
                  h_d    = '0;
                  cgrp_d = cgrp_q + GrpOne;
               end
            end
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q    <= StIdle;
         op_en_d1_q <= 1'b0;
         width_q    <= '0;
         height_q   <= '0;
         channel_q  <= '0;
         lane_q     <= '0;
         w_q        <= '0;
         h_q        <= '0;
         cgrp_q     <= '0;
         valid_q    <= 1'b0;
         pd_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_en_d1_q <= reg2dp_op_en;
         lane_q     <= lane_d;
         w_q        <= w_d;
         h_q        <= h_d;
         cgrp_q     <= cgrp_d;
         if ((state_q == StIdle) && op_en_rise) begin
            width_q   <= reg2dp_width;
            height_q  <= reg2dp_height;
            channel_q <= reg2dp_channel;
         end
         if (rd_fire) begin
            valid_q <= 1'b1;
            pd_q    <= {info, rd_data};
         end else if (cdp_rdma2dp_ready) begin
            valid_q <= 1'b0;
         end
         done_q <= (state_q == StDrain) & out_fire;
      end
   end

`ifdef CDP_RDMA_TX_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         stall_q <= '0;
      end else if ((state_q == StIdle) && op_en_rise) begin
         stall_q <= '0;
      end else if (valid_q && !cdp_rdma2dp_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign dp2reg_rdma_stall = stall_q;
`endif

   assign cdp_rdma2dp_valid = valid_q;
   assign cdp_rdma2dp_pd    = pd_q;
   assign rdma2glb_done     = done_q;

endmodule
